// File: rtl/regex_pkg.sv
// Shared definitions for the regex stream driver: FSM states and the byte width.
package regex_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regex_bit_serializer.sv
// Byte-to-bit serializer, MSB first, with same-cycle reload so consecutive bytes
// stream without a bubble.
module regex_bit_serializer
  import regex_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_byte,
  input  logic              load_last,
  input  logic              shift,
  output logic              bit_out,
  output logic              cnt_zero,
  output logic              cur_last
);

  logic [BYTE_W-1:0] shreg_reg;
  logic [2:0]        bit_cnt_reg;
  logic              last_reg;

  // A load wins over a shift: this is the bubble-free reload on the final bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      last_reg    <= 1'b0;
    end else if (load) begin
      shreg_reg   <= load_byte;
      bit_cnt_reg <= 3'd7;
      last_reg    <= load_last;
    end else if (shift) begin
      shreg_reg   <= {shreg_reg[BYTE_W-2:0], 1'b0};
      bit_cnt_reg <= bit_cnt_reg - 3'd1;
    end
  end

  assign bit_out  = shreg_reg[BYTE_W-1];
  assign cnt_zero = (bit_cnt_reg == 3'd0);
  assign cur_last = last_reg;

endmodule

// File: rtl/regex_stream_driver.sv
// Feeds a byte stream bit-serially into a regex matcher network and records matches.
// Define REGEX_MATCH_COUNT_EN to add the saturating match_count output.
module regex_stream_driver
  import regex_pkg::*;
#(
  parameter int ANCHORED = 0,
  parameter int POS_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              re_rst,
  output logic              re_i,
  output logic              re_c,
  input  logic              re_o,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              match_found,
  output logic [POS_W-1:0]  first_pos
`ifdef REGEX_MATCH_COUNT_EN
  ,
  output logic [POS_W-1:0]  match_count
`endif
);

  state_t           state_reg;
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_prev_reg;
  logic [POS_W-1:0] pos_next;
  logic [POS_W-1:0] first_pos_reg;
  logic             underrun_reg;
  logic             match_found_reg;
  logic             ser_bit;
  logic             ser_cnt_zero;
  logic             ser_last;
  logic             in_shift;
  logic             accept;
  logic             match_hit;

  assign in_shift = (state_reg == ST_SHIFT);
  assign in_ready = (state_reg == ST_IDLE) || (in_shift && ser_cnt_zero && !ser_last);
  assign accept   = in_valid && in_ready;
  assign re_rst   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign re_c     = in_shift && ser_bit;
  assign re_i     = in_shift && ((ANCHORED == 0) || (pos_reg == '0));
  assign busy     = in_shift || (state_reg == ST_DRAIN);
  assign done     = (state_reg == ST_DONE);
  assign pos_next = (&pos_reg) ? pos_reg : pos_reg + 1'b1;

  // re_o is one cycle late, so it reports on the previous bit; the first SHIFT
  // cycle (pos 0) would only see the network still coming out of reset.
  assign match_hit = re_o && ((in_shift && (pos_reg != '0)) || (state_reg == ST_DRAIN));

  regex_bit_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_byte (in_byte),
    .load_last (in_last),
    .shift     (in_shift),
    .bit_out   (ser_bit),
    .cnt_zero  (ser_cnt_zero),
    .cur_last  (ser_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      pos_reg         <= '0;
      pos_prev_reg    <= '0;
      first_pos_reg   <= '0;
      underrun_reg    <= 1'b0;
      match_found_reg <= 1'b0;
    end else begin
      pos_prev_reg <= pos_reg;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg       <= ST_SHIFT;
            pos_reg         <= '0;
            first_pos_reg   <= '0;
            underrun_reg    <= 1'b0;
            match_found_reg <= 1'b0;
          end
        end
        ST_SHIFT: begin
          pos_reg <= pos_next;
          if (ser_cnt_zero) begin
            if (ser_last) begin
              state_reg <= ST_DRAIN;
            end else if (!accept) begin
              underrun_reg <= 1'b1;
              state_reg    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: state_reg <= ST_DONE;
        default:  state_reg <= ST_IDLE;
      endcase
      if (match_hit && !match_found_reg) begin
        match_found_reg <= 1'b1;
        first_pos_reg   <= pos_prev_reg;
      end
    end
  end

`ifdef REGEX_MATCH_COUNT_EN
  logic [POS_W-1:0] match_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count_reg <= '0;
    end else if ((state_reg == ST_IDLE) && accept) begin
      match_count_reg <= '0;
    end else if (match_hit && !(&match_count_reg)) begin
      match_count_reg <= match_count_reg + 1'b1;
    end
  end

  assign match_count = match_count_reg;
`endif

  assign underrun    = underrun_reg;
  assign match_found = match_found_reg;
  assign first_pos   = first_pos_reg;

endmodule

// File: tb/tb_regex_stream_driver.sv
// Bench for regex_stream_driver: unanchored and anchored instances share one stream,
// each driving its own "01" matcher model; a stream-level model predicts every cycle.
module tb_regex_stream_driver;

  localparam int POS_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_last;
  logic [7:0] in_byte;

  logic u_in_ready, u_re_rst, u_re_i, u_re_c, u_re_o, u_busy, u_done, u_underrun, u_mf;
  logic a_in_ready, a_re_rst, a_re_i, a_re_c, a_re_o, a_busy, a_done, a_underrun, a_mf;
  logic [POS_W-1:0] u_fp, a_fp, u_mc, a_mc;
  logic u_ma, u_mb, a_ma, a_mb;

  int n_cmp = 0;
  int n_bad = 0;

  bit bits_q[$];
  bit blast_q[$];
  int nbits;
  bit exp_ur;
  bit exp_mf[2];
  int exp_fp[2];
  int exp_cnt[2];

  bit go = 1'b0;
  bit active = 1'b0;
  int k;

  always #5 clk = ~clk;

  regex_stream_driver #(.ANCHORED(0), .POS_W(POS_W)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_byte(in_byte), .in_last(in_last), .re_rst(u_re_rst), .re_i(u_re_i),
    .re_c(u_re_c), .re_o(u_re_o), .busy(u_busy), .done(u_done),
    .underrun(u_underrun), .match_found(u_mf), .first_pos(u_fp)
`ifdef REGEX_MATCH_COUNT_EN
    , .match_count(u_mc)
`endif
  );

  regex_stream_driver #(.ANCHORED(1), .POS_W(POS_W)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_byte(in_byte), .in_last(in_last), .re_rst(a_re_rst), .re_i(a_re_i),
    .re_c(a_re_c), .re_o(a_re_o), .busy(a_busy), .done(a_done),
    .underrun(a_underrun), .match_found(a_mf), .first_pos(a_fp)
`ifdef REGEX_MATCH_COUNT_EN
    , .match_count(a_mc)
`endif
  );

`ifndef REGEX_MATCH_COUNT_EN
  assign u_mc = '0;
  assign a_mc = '0;
`endif

  // "01" matcher networks with a registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset || u_re_rst) begin
      u_ma <= 1'b0;
      u_mb <= 1'b0;
    end else begin
      u_ma <= u_re_i & ~u_re_c;
      u_mb <= u_ma & u_re_c;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || a_re_rst) begin
      a_ma <= 1'b0;
      a_mb <= 1'b0;
    end else begin
      a_ma <= a_re_i & ~a_re_c;
      a_mb <= a_ma & a_re_c;
    end
  end
  assign u_re_o = u_mb;
  assign a_re_o = a_mb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Stream model: bit list, per-byte last flags, and "01" matches counted from the rules
  task automatic set_stream(input logic [7:0] b0, input logic [7:0] b1, input int nb, input bit lastf);
    bits_q.delete();
    blast_q.delete();
    for (int j = 0; j < nb; j++) begin
      logic [7:0] b;
      b = (j == 0) ? b0 : b1;
      for (int t = 7; t >= 0; t--) bits_q.push_back(b[t]);
      blast_q.push_back(lastf && (j == nb - 1));
    end
    nbits  = bits_q.size();
    exp_ur = !lastf;
    for (int x = 0; x < 2; x++) begin
      exp_mf[x]  = 1'b0;
      exp_fp[x]  = 0;
      exp_cnt[x] = 0;
      for (int p = 1; p < nbits; p++) begin
        bit start_ok;
        start_ok = (x == 0) || (p - 1 == 0);
        if (start_ok && !bits_q[p-1] && bits_q[p]) begin
          if (!exp_mf[x]) begin
            exp_mf[x] = 1'b1;
            exp_fp[x] = p;
          end
          exp_cnt[x]++;
        end
      end
    end
  endtask

  task automatic cmp_cycle(input int x, input int kk, input logic rdy, input logic rrst,
                           input logic c, input logic i, input logic bsy, input logic dn,
                           input logic ur, input logic mf, input logic [POS_W-1:0] fp,
                           input logic [POS_W-1:0] mc);
    string pfx;
    logic e_rdy, e_c, e_i, e_busy, e_done;
    pfx = (x == 0) ? "unan" : "anch";
    e_rdy = 1'b0; e_c = 1'b0; e_i = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (kk < nbits) begin
      e_rdy  = ((kk % 8) == 7) && !blast_q[kk/8];
      e_c    = bits_q[kk];
      e_i    = (x == 0) || (kk == 0);
      e_busy = 1'b1;
    end else if (kk == nbits) begin
      e_busy = 1'b1;
    end else begin
      e_done = 1'b1;
    end
    chk($sformatf("%s in_ready k=%0d", pfx, kk), rdy, e_rdy);
    chk($sformatf("%s re_c k=%0d", pfx, kk), c, e_c);
    chk($sformatf("%s re_i k=%0d", pfx, kk), i, e_i);
    chk($sformatf("%s busy k=%0d", pfx, kk), bsy, e_busy);
    chk($sformatf("%s done k=%0d", pfx, kk), dn, e_done);
    if (kk <= nbits) chk($sformatf("%s re_rst k=%0d", pfx, kk), rrst, 1'b0);
    if (kk == nbits + 1) begin
      chk($sformatf("%s underrun", pfx), ur, exp_ur);
      chk($sformatf("%s match_found", pfx), mf, exp_mf[x]);
      chk($sformatf("%s first_pos", pfx), fp, exp_fp[x]);
`ifdef REGEX_MATCH_COUNT_EN
      chk($sformatf("%s match_count", pfx), mc, exp_cnt[x]);
`endif
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (go) begin
        k = 0;
        active = 1'b1;
        go = 1'b0;
      end
      if (active) begin
        cmp_cycle(0, k, u_in_ready, u_re_rst, u_re_c, u_re_i, u_busy, u_done, u_underrun, u_mf, u_fp, u_mc);
        cmp_cycle(1, k, a_in_ready, a_re_rst, a_re_c, a_re_i, a_busy, a_done, a_underrun, a_mf, a_fp, a_mc);
        if (k == nbits + 1) active = 1'b0;
        else k++;
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, " u in_ready"}, u_in_ready, 1'b1);
    chk({nm, " u re_rst"}, u_re_rst, 1'b1);
    chk({nm, " u re_i"}, u_re_i, 1'b0);
    chk({nm, " u re_c"}, u_re_c, 1'b0);
    chk({nm, " u busy"}, u_busy, 1'b0);
    chk({nm, " u done"}, u_done, 1'b0);
    chk({nm, " u underrun"}, u_underrun, 1'b0);
    chk({nm, " u match_found"}, u_mf, 1'b0);
    chk({nm, " u first_pos"}, u_fp, 0);
    chk({nm, " a re_i"}, a_re_i, 1'b0);
    chk({nm, " a busy"}, a_busy, 1'b0);
    chk({nm, " a match_found"}, a_mf, 1'b0);
`ifdef REGEX_MATCH_COUNT_EN
    chk({nm, " u match_count"}, u_mc, 0);
`endif
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit lastf, input bit first);
    bit ok;
    logic rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = lastf;
    for (int n = 0; n < 40 && !ok; n++) begin
      rdy = u_in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        #1;
        if (first) go = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %0h not accepted in 40 cycles, want accepted", b);
    end
  endtask

  task automatic wait_end();
    for (int n = 0; n < 80 && (go || active); n++) @(posedge clk);
    if (go || active) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: stream still active after 80 cycles, want done");
      go = 1'b0;
      active = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_stream(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                            input int nb, input bit lastf);
    set_stream(b0, b1, nb, lastf);
    send_byte(b0, (nb == 1) && lastf, 1'b1);
    if (nb == 2) send_byte(b1, lastf, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_end();
    chk({nm, " idle in_ready"}, u_in_ready, 1'b1);
    chk({nm, " idle done"}, u_done, 1'b0);
    chk({nm, " held match_found"}, u_mf, exp_mf[0]);
    chk({nm, " held first_pos"}, u_fp, exp_fp[0]);
    chk({nm, " held underrun"}, u_underrun, exp_ur);
    $display("stream %s: %0d bits, unan mf=%0d fp=%0d, anch mf=%0d fp=%0d, underrun=%0d",
             nm, nbits, u_mf, u_fp, a_mf, a_fp, u_underrun);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    run_stream("t1_0x40", 8'h40, 8'h00, 1, 1'b1);
    chk("t1 lit u first_pos", u_fp, 1);
    chk("t1 lit u match_found", u_mf, 1'b1);
    chk("t1 lit a first_pos", a_fp, 1);

    run_stream("t2_0x20", 8'h20, 8'h00, 1, 1'b1);
    chk("t2 lit a match_found", a_mf, 1'b0);
    chk("t2 lit u first_pos", u_fp, 2);

    run_stream("t3_ff01", 8'hFF, 8'h01, 2, 1'b1);
    chk("t3 lit u first_pos", u_fp, 15);
    chk("t3 lit a match_found", a_mf, 1'b0);

    run_stream("t4_underrun", 8'h40, 8'h00, 1, 1'b0);
    chk("t4 lit u underrun", u_underrun, 1'b1);
    chk("t4 lit a underrun", a_underrun, 1'b1);

    // Mid-stream reset at pos 5, after a match has been captured
    set_stream(8'h40, 8'h00, 1, 1'b1);
    send_byte(8'h40, 1'b1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst lit pre match_found", u_mf, 1'b1);
    #2;
    reset  = 1'b1;
    active = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("stream midrst: reset at pos 5, outputs back to reset values");

    run_stream("t5_0x55", 8'h55, 8'h00, 1, 1'b1);
    chk("t5 lit u first_pos", u_fp, 1);
`ifdef REGEX_MATCH_COUNT_EN
    chk("t5 lit u match_count", u_mc, 4);
    chk("t5 lit a match_count", a_mc, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regex_stream_driver.md
REGEX_STREAM_DRIVER -- requirements
Module: regex_stream_driver

Interface
REQ-001 SHALL have parameter ANCHORED, default 0; 1 means the start token is injected only on stream bit 0, 0 means it is injected on every bit.
REQ-002 SHALL have parameter POS_W, default 16; width of the bit-position and count fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, byte offered.
REQ-006 SHALL have port in_ready, output, 1, byte accepted when in_valid&in_ready.
REQ-007 SHALL have port in_byte, input, 8, stream byte, transmitted MSB first.
REQ-008 SHALL have port in_last, input, 1, marks the final byte of the stream.
REQ-009 SHALL have port re_rst, output, 1, reset to the matcher network.
REQ-010 SHALL have port re_i, output, 1, start token to the matcher network.
REQ-011 SHALL have port re_c, output, 1, current stream bit to the matcher network.
REQ-012 SHALL have port re_o, input, 1, registered match output from the matcher network.
REQ-013 SHALL have ports busy (1), done (1), underrun (1), match_found (1) and first_pos (POS_W), all outputs.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> DRAIN -> DONE -> IDLE.
- IDLE: in_ready=1, re_rst=1; an accepted byte loads the shift register and bit counter=7, then -> SHIFT.
REQ-015 SHALL, in SHIFT, drive re_c=shreg[7], re_rst=0, then shift left one bit and increment pos (0-based stream bit index) on each cycle.
REQ-016 SHALL drive re_i=1 on every SHIFT cycle when ANCHORED=0, and only when pos==0 when ANCHORED=1.
REQ-017 SHALL assert in_ready in SHIFT only on bit-counter==0 cycles where the current byte is not the last; an accept there reloads with no bubble.
REQ-018 SHALL, on bit-counter==0: if the last byte, -> DRAIN; else if no accept, set underrun=1 (sticky) and -> DRAIN.
REQ-019 SHALL spend DRAIN exactly one cycle (re_i=0, re_c=0, re_rst=0) to sample the final registered re_o, then -> DONE.
REQ-020 SHALL treat re_o==1 seen in cycle t (SHIFT or DRAIN) as a match ending at stream bit pos_d = pos of cycle t-1; re_o in IDLE/DONE and in the first SHIFT cycle is ignored.
REQ-021 SHALL, on the first match of a stream, set match_found=1 and first_pos=pos_d; later matches do not alter first_pos.
REQ-022 SHALL saturate pos at 2^POS_W-1; bits beyond it are still transmitted.
REQ-023 SHALL make DONE last one cycle with done=1; match_found, first_pos and underrun are held until the next IDLE accept, which clears them.
REQ-024 SHALL drive busy=1 in SHIFT and DRAIN.

Reset
REQ-025 SHALL, on reset (any time, including mid-stream), go immediately to IDLE: in_ready=1, re_rst=1, re_i=0, re_c=0, busy=0, done=0, underrun=0, match_found=0, first_pos=0, pos=0, shreg=0.

Configuration
REQ-026 SHALL, with REGEX_MATCH_COUNT_EN defined, add output match_count (POS_W) counting every re_o match per REQ-020, saturating at all-ones, cleared like match_found.
REQ-027 SHALL, without REGEX_MATCH_COUNT_EN, have no match_count port or counter; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum and the byte width constant (8) in shared package regex_pkg.
REQ-029 SHALL keep the serializer (shreg, bit counter, reload) in one sub-module regex_bit_serializer; FSM, position and match capture stay in the top.

Verification
REQ-030 SHALL cover: unanchored, 1-byte stream 0x40 (last) with a matcher model for "01" -> re_o at the cycle after bit 1, match_found=1, first_pos=1, done 10 cycles after accept.
REQ-031 SHALL cover: ANCHORED=1, stream 0x20 with "01" model -> re_i high only on the first SHIFT cycle, match_found=0.
REQ-032 SHALL cover: two bytes 0xFF, 0x01 (last) offered back-to-back -> 16 contiguous SHIFT cycles, no bubble, "01" match at first_pos=15.
REQ-033 SHALL cover: first byte not last, in_valid low at its bit 0 -> underrun=1, DRAIN, done pulse.
REQ-034 SHALL cover: reset asserted at pos=5 -> all outputs at reset values in the same cycle; a new stream then runs normally.
REQ-035 SHALL cover: with REGEX_MATCH_COUNT_EN, stream 0x55 (last), "01" model -> match_count=4, first_pos=1.
